// File: rtl/hdlc_tx_if.sv
// Tx buffer / register side of the HDLC transmit sequencer, plus the line and status outputs.
// The master drives requests and buffer read data; the slave is the frame controller.
interface hdlc_tx_if;
  logic       Tx_Enable;
  logic [7:0] Tx_FrameSize;
  logic       Tx_AbortFrame;
  logic [7:0] Tx_Data;
  logic       Tx_RdBuff;
  logic       Tx;
  logic       Tx_ValidFrame;
  logic       Tx_AbortedTrans;
  logic       Tx_Done;

  modport master (
    output Tx_Enable, Tx_FrameSize, Tx_AbortFrame, Tx_Data,
    input  Tx_RdBuff, Tx, Tx_ValidFrame, Tx_AbortedTrans, Tx_Done
  );

  modport slave (
    input  Tx_Enable, Tx_FrameSize, Tx_AbortFrame, Tx_Data,
    output Tx_RdBuff, Tx, Tx_ValidFrame, Tx_AbortedTrans, Tx_Done
  );
endinterface

// File: rtl/hdlc_tx_frame_ctrl.sv
// HDLC transmit sequencer: opening flag, zero-stuffed LSB-first payload fetched from the
// Tx buffer, closing flag, and the abort pattern. Every output is registered.
module hdlc_tx_frame_ctrl #(
  parameter int unsigned MAX_BYTES = 126
) (
  input logic       Clk,
  input logic       Rst,
  hdlc_tx_if.slave  bus
);

  localparam logic [7:0] FLAG     = 8'h7E;
  localparam logic [7:0] MAX_SIZE = 8'(MAX_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    START_FLAG,
    DATA,
    END_FLAG,
    ABORT_GAP,
    ABORT_FLAG
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] size_q, size_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [2:0] flag_cnt_q, flag_cnt_d;
  logic [2:0] ones_q, ones_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] hold_q, hold_d;
  logic       data_vld_q;
  logic       tail_q, tail_d;
  logic       tx_q, tx_d;
  logic       valid_q, valid_d;
  logic       abt_q, abt_d;
  logic       rd_q, rd_d;
  logic       done_q, done_d;

  logic       size_ok;
  logic       abort_req;
  logic [7:0] load_byte;
  logic [7:0] cur_byte;
  logic [7:0] cur_cnt;
  logic       is_last;
  logic [2:0] ones_inc;

  assign size_ok   = (bus.Tx_FrameSize != 8'd0) && (bus.Tx_FrameSize <= MAX_SIZE);
  assign abort_req = valid_q && bus.Tx_AbortFrame;

  // Buffer data is only valid the cycle after a pop; the hold register covers a load
  // that a stuff bit pushed one or two cycles later.
  assign load_byte = data_vld_q ? bus.Tx_Data : hold_q;
  assign cur_byte  = (bit_idx_q == 3'd0) ? load_byte : sr_q;
  assign cur_cnt   = (bit_idx_q == 3'd0) ? byte_cnt_q + 8'd1 : byte_cnt_q;
  assign is_last   = (cur_cnt == size_q);
  assign ones_inc  = cur_byte[0] ? ones_q + 3'd1 : 3'd0;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no branch can infer a latch.
    state_d    = state_q;
    size_d     = size_q;
    byte_cnt_d = byte_cnt_q;
    bit_idx_d  = bit_idx_q;
    flag_cnt_d = flag_cnt_q;
    ones_d     = ones_q;
    sr_d       = sr_q;
    tail_d     = tail_q;
    hold_d     = data_vld_q ? bus.Tx_Data : hold_q;
    tx_d       = 1'b1;
    valid_d    = valid_q;
    abt_d      = abt_q;
    rd_d       = 1'b0;
    done_d     = 1'b0;

    // Only START_FLAG and DATA run with valid_q set, so this covers exactly those states.
    if (abort_req) begin
      state_d = ABORT_GAP;
      valid_d = 1'b0;
      abt_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.Tx_Enable && size_ok) begin
            state_d    = START_FLAG;
            size_d     = bus.Tx_FrameSize;
            abt_d      = 1'b0;
            valid_d    = 1'b1;
            flag_cnt_d = 3'd0;
          end
        end

        START_FLAG: begin
          tx_d       = FLAG[flag_cnt_q];
          flag_cnt_d = flag_cnt_q + 3'd1;
          rd_d       = (flag_cnt_q == 3'd6);
          if (flag_cnt_q == 3'd7) begin
            state_d    = DATA;
            ones_d     = 3'd0;
            bit_idx_d  = 3'd0;
            byte_cnt_d = 8'd0;
          end
        end

        DATA: begin
          if (ones_q == 3'd5) begin
            // Stuffed zero: shift register stalls; a trailing stuff bit closes the payload.
            tx_d   = 1'b0;
            ones_d = 3'd0;
            if ((bit_idx_q == 3'd0) && (byte_cnt_q == size_q)) begin
              state_d    = END_FLAG;
              valid_d    = 1'b0;
              flag_cnt_d = 3'd0;
            end
          end else begin
            tx_d       = cur_byte[0];
            sr_d       = {1'b0, cur_byte[7:1]};
            bit_idx_d  = bit_idx_q + 3'd1;
            byte_cnt_d = cur_cnt;
            ones_d     = ones_inc;
            rd_d       = (bit_idx_q == 3'd6) && !is_last;
            if ((bit_idx_q == 3'd7) && is_last && (ones_inc != 3'd5)) begin
              state_d    = END_FLAG;
              valid_d    = 1'b0;
              flag_cnt_d = 3'd0;
            end
          end
        end

        END_FLAG: begin
          if (tail_q) begin
            tail_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            tx_d       = FLAG[flag_cnt_q];
            flag_cnt_d = flag_cnt_q + 3'd1;
            tail_d     = (flag_cnt_q == 3'd7);
          end
        end

        ABORT_GAP: begin
          tx_d       = 1'b0;
          state_d    = ABORT_FLAG;
          flag_cnt_d = 3'd0;
        end

        ABORT_FLAG: begin
          flag_cnt_d = flag_cnt_q + 3'd1;
          if (flag_cnt_q == 3'd7) begin
            state_d = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= IDLE;
      size_q     <= 8'd0;
      byte_cnt_q <= 8'd0;
      bit_idx_q  <= 3'd0;
      flag_cnt_q <= 3'd0;
      ones_q     <= 3'd0;
      sr_q       <= 8'd0;
      hold_q     <= 8'd0;
      data_vld_q <= 1'b0;
      tail_q     <= 1'b0;
      tx_q       <= 1'b1;
      valid_q    <= 1'b0;
      abt_q      <= 1'b0;
      rd_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      byte_cnt_q <= byte_cnt_d;
      bit_idx_q  <= bit_idx_d;
      flag_cnt_q <= flag_cnt_d;
      ones_q     <= ones_d;
      sr_q       <= sr_d;
      hold_q     <= hold_d;
      data_vld_q <= rd_q;
      tail_q     <= tail_d;
      tx_q       <= tx_d;
      valid_q    <= valid_d;
      abt_q      <= abt_d;
      rd_q       <= rd_d;
      done_q     <= done_d;
    end
  end

  assign bus.Tx              = tx_q;
  assign bus.Tx_ValidFrame   = valid_q;
  assign bus.Tx_AbortedTrans = abt_q;
  assign bus.Tx_RdBuff       = rd_q;
  assign bus.Tx_Done         = done_q;

endmodule

// File: tb/tb_hdlc_tx_frame_ctrl.sv
// Bench for hdlc_tx_frame_ctrl: directed and randomized frames compared cycle by cycle
// against a bit-stream model built from the framing rules, with a Tx buffer emulator.
module tb_hdlc_tx_frame_ctrl;

  localparam int MAX_BYTES = 126;
  localparam int EXP_LEN   = 2048;

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  hdlc_tx_if bus ();

  hdlc_tx_frame_ctrl #(.MAX_BYTES(MAX_BYTES)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] frame_q[$];
  bit         sticky_abt = 1'b0;
  bit         exp_tx   [EXP_LEN];
  bit         exp_vf   [EXP_LEN];
  bit         exp_rd   [EXP_LEN];
  bit         exp_done [EXP_LEN];
  bit         exp_abt  [EXP_LEN];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_line(input string tag, input bit etx, input bit evf, input bit erd,
                            input bit edone, input bit eabt);
    check({tag, ".tx"}, 32'(bus.Tx), 32'(etx));
    check({tag, ".valid"}, 32'(bus.Tx_ValidFrame), 32'(evf));
    check({tag, ".rd"}, 32'(bus.Tx_RdBuff), 32'(erd));
    check({tag, ".done"}, 32'(bus.Tx_Done), 32'(edone));
    check({tag, ".aborted"}, 32'(bus.Tx_AbortedTrans), 32'(eabt));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_line($sformatf("idle%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, sticky_abt);
    end
  endtask

  // abort_at: 0 none, >0 relative cycle, -1 last valid cycle, -2 random cycle in the valid window.
  task automatic run_frame(input string name, input int abort_at_in, input int reset_at,
                           input bit poke);
    logic [7:0] flag;
    bit         s[$];
    int         rd_rel[$];
    int         n, p, total, ones, pop, exp_pops, run, max_run, abort_at;
    bit         rd_seen;
    flag    = 8'h7E;
    n       = frame_q.size();
    ones    = 0;
    rd_rel.push_back(8);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        s.push_back(frame_q[i][b]);
        if (b == 6 && i < n - 1) rd_rel.push_back(9 + s.size());
        ones = frame_q[i][b] ? ones + 1 : 0;
        if (ones == 5) begin
          s.push_back(1'b0);
          ones = 0;
        end
      end
    end
    p     = s.size();
    total = 18 + p;
    abort_at = abort_at_in;
    if (abort_at_in == -1) abort_at = 8 + p;
    if (abort_at_in == -2) abort_at = $urandom_range(1, 8 + p);

    for (int r = 0; r <= total; r++) begin
      exp_tx[r]   = 1'b1;
      exp_vf[r]   = (r >= 1 && r <= 8 + p);
      exp_rd[r]   = 1'b0;
      exp_done[r] = (r == total);
      exp_abt[r]  = (r == 0) ? sticky_abt : 1'b0;
      if (r >= 2 && r <= 9) exp_tx[r] = flag[r-2];
      else if (r >= 10 && r <= 9 + p) exp_tx[r] = s[r-10];
      else if (r >= 10 + p && r <= 17 + p) exp_tx[r] = flag[r-10-p];
    end
    foreach (rd_rel[k]) exp_rd[rd_rel[k]] = 1'b1;
    exp_pops = n;
    if (abort_at > 0) begin
      exp_pops = 0;
      foreach (rd_rel[k]) if (rd_rel[k] <= abort_at) exp_pops++;
      for (int r = abort_at + 1; r <= abort_at + 10; r++) begin
        exp_tx[r]   = (r != abort_at + 2);
        exp_vf[r]   = 1'b0;
        exp_rd[r]   = 1'b0;
        exp_done[r] = 1'b0;
        exp_abt[r]  = 1'b1;
      end
      total = abort_at + 10;
    end

    check_line({name, "@0"}, exp_tx[0], exp_vf[0], exp_rd[0], exp_done[0], exp_abt[0]);
    bus.Tx_Enable    = 1'b1;
    bus.Tx_FrameSize = 8'(n);
    pop     = 0;
    rd_seen = 1'b0;
    run     = 0;
    max_run = 0;
    for (int r = 1; r <= total; r++) begin
      tick();
      bus.Tx_Enable = 1'b0;
      check_line($sformatf("%s@%0d", name, r), exp_tx[r], exp_vf[r], exp_rd[r], exp_done[r],
                 exp_abt[r]);
      if (r == reset_at) begin
        #2 Rst = 1'b0;
        #1;
        check_line({name, ".in_reset"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.Tx_AbortFrame = 1'b0;
        #3 Rst = 1'b1;
        sticky_abt = 1'b0;
        tick();
        check_line({name, ".after_reset"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        return;
      end
      if (rd_seen) begin
        bus.Tx_Data = (pop < n) ? frame_q[pop] : 8'h00;
        pop++;
      end else begin
        bus.Tx_Data = 8'($urandom);
      end
      rd_seen = bus.Tx_RdBuff;
      bus.Tx_AbortFrame = (r == abort_at) || (abort_at <= 0 && r == 12 + p);
      if (poke && r == 12) begin
        bus.Tx_Enable    = 1'b1;
        bus.Tx_FrameSize = 8'd5;
      end
      if (r >= 10 && r <= 9 + p) begin
        run     = bus.Tx ? run + 1 : 0;
        max_run = (run > max_run) ? run : max_run;
      end
    end
    bus.Tx_AbortFrame = 1'b0;
    check({name, ".pops"}, 32'(pop), 32'(exp_pops));
    if (abort_at <= 0) check({name, ".six_ones"}, 32'(max_run > 5), 32'd0);
    sticky_abt = (abort_at > 0);
    idle_cycles(2);
  endtask

  task automatic illegal_req(input logic [7:0] size);
    bus.Tx_Enable    = 1'b1;
    bus.Tx_FrameSize = size;
    tick();
    bus.Tx_Enable = 1'b0;
    check_line($sformatf("illegal%0d", size), 1'b1, 1'b0, 1'b0, 1'b0, sticky_abt);
    idle_cycles(12);
  endtask

  initial begin
    int sel;
    bus.Tx_Enable     = 1'b0;
    bus.Tx_FrameSize  = 8'd0;
    bus.Tx_AbortFrame = 1'b0;
    bus.Tx_Data       = 8'd0;

    tick();
    tick();
    check_line("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #3 Rst = 1'b1;
    idle_cycles(3);

    frame_q = '{8'h55};
    run_frame("b55", 0, 0, 1'b0);
    frame_q = '{8'hFF};
    run_frame("bFF", 0, 0, 1'b0);
    frame_q = '{8'hF8};
    run_frame("bF8", 0, 0, 1'b0);
    frame_q = '{8'h01, 8'h02, 8'h03};
    run_frame("b123_poke", 0, 0, 1'b1);
    frame_q = '{8'hA5, 8'h3C, 8'hFF, 8'h0F};
    run_frame("abort4", 20, 0, 1'b0);

    illegal_req(8'd0);
    illegal_req(8'd127);
    illegal_req(8'd255);

    frame_q = '{8'h7E, 8'hFF};
    run_frame("after_abort", 0, 0, 1'b0);
    frame_q = '{8'hF8, 8'h1F};
    run_frame("abort_last", -1, 0, 1'b0);
    frame_q = '{8'h11};
    run_frame("abort_first", 1, 0, 1'b0);

    frame_q.delete();
    for (int i = 0; i < MAX_BYTES; i++) frame_q.push_back(8'($urandom));
    run_frame("max", 0, 0, 1'b0);

    for (int f = 0; f < 24; f++) begin
      frame_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 10)); i++) begin
        sel = $urandom_range(0, 3);
        frame_q.push_back(sel == 0 ? 8'hFF : (sel == 1 ? 8'hF8 : 8'($urandom)));
      end
      sel = $urandom_range(0, 3);
      run_frame($sformatf("rnd%0d", f), sel == 0 ? -2 : (sel == 1 ? -1 : 0), 0, 1'b0);
    end

    frame_q = '{8'hC3, 8'h96, 8'h5A};
    run_frame("reset_mid", 0, 14, 1'b0);
    idle_cycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdlc_tx_frame_ctrl.md
Name: hdlc_tx_frame_ctrl

Overview:
Transmit-side sequencer for the HDLC link. It takes a frame-start request and byte count, fetches payload bytes from the Tx buffer, and serialises them onto Tx. Along the way it generates the opening and closing flags (0x7E), inserts a zero after five consecutive ones, drives idle marks and produces the abort pattern on request. It sits between the Tx buffer/register interface and the line pin, and generates Tx_ValidFrame and Tx_AbortedTrans for status and assertions.

Parameters:
MAX_BYTES, 126, largest accepted payload byte count (Tx_FrameSize legal range 1..MAX_BYTES).

Ports:
Clk  input  1  system clock, all logic on rising edge
Rst  input  1  asynchronous, active-low reset
Tx_Enable  input  1  frame-start request, sampled in IDLE only
Tx_FrameSize  input  8  payload byte count, captured when Tx_Enable is accepted
Tx_AbortFrame  input  1  abort request, acted on only while Tx_ValidFrame=1
Tx_Data  input  8  buffer read data, valid the cycle after Tx_RdBuff
Tx_RdBuff  output  1  one-cycle pop request to the Tx buffer, one per payload byte
Tx  output  1  serial line, registered, LSB first
Tx_ValidFrame  output  1  high while the frame payload phase is active
Tx_AbortedTrans  output  1  sticky abort status
Tx_Done  output  1  one-cycle pulse after a frame completes normally

Behaviour:
- Reset (async, Rst=0): Tx=1, Tx_ValidFrame=0, Tx_AbortedTrans=0, Tx_RdBuff=0, Tx_Done=0, state IDLE, all counters 0. Reset mid-frame drops the frame immediately; there is no partial flag.
- States: IDLE, START_FLAG, DATA, END_FLAG, ABORT_GAP, ABORT_FLAG.
- IDLE:
  - Tx=1.
  - Tx_Enable=1 with 1<=Tx_FrameSize<=MAX_BYTES: capture size and clear Tx_AbortedTrans.
  - Tx_FrameSize=0 or >MAX_BYTES: request ignored, no other effect.
  - Tx_Enable outside IDLE: ignored.
- Start timing, accept at cycle n:
  - n+1: Tx_ValidFrame=1.
  - n+2..n+9: Tx = flag bits 0,1,1,1,1,1,1,0 (START_FLAG).
  - Tx_RdBuff pulses at n+8; Tx_Data is latched at n+9 into the hold register.
  - First payload bit on Tx at n+10.
- DATA:
  - Shift register loads from the hold register after the previous byte's bit 7 (or its trailing stuff bit), so there is no gap cycle on Tx.
  - For each byte except the last, Tx_RdBuff pulses once, in the first cycle that byte's bit index 6 is on Tx.
  - Exactly Tx_FrameSize pops per normal frame.
- Zero insertion (DATA only):
  - A 3-bit ones counter counts consecutive 1s on Tx. It clears on entering DATA and on any 0.
  - After five 1s, the next Tx cycle is a stuffed 0, the shift register stalls, and the counter clears.
  - Applies to the final byte too: a trailing stuff bit belongs to DATA.
  - Flags and the abort pattern are never stuffed.
- End timing:
  - Tx_ValidFrame=0 in the cycle the last payload bit (or trailing stuff bit) is on Tx.
  - END_FLAG drives the 8 flag bits in the following 8 cycles.
  - Tx_Done=1 for the one cycle after the last flag bit; state returns to IDLE (Tx=1).
- Abort (Tx_AbortFrame=1 sampled at cycle a while Tx_ValidFrame=1):
  - a+1: Tx_ValidFrame=0, Tx_AbortedTrans=1, Tx=1 (ABORT_GAP); no further Tx_RdBuff.
  - a+2: Tx=0.
  - a+3..a+9: Tx=1 (ABORT_FLAG).
  - a+10: IDLE. Remaining buffer bytes are not popped. No Tx_Done.
  - Tx_AbortedTrans holds until the next accepted Tx_Enable.
  - Abort in the same cycle as the last payload bit wins over END_FLAG.
  - Tx_AbortFrame during END_FLAG or IDLE: ignored.
- Counters: byte counter 8 bit, bit index 3 bit (wraps 7->0 on load), flag bit counter 3 bit.
- Line invariants:
  - Tx never shows six consecutive 1s between the opening and closing flags.
  - In IDLE, Tx is constant 1.

Test Plan:
- Reset: assert Rst=0 mid-DATA -> Tx=1, Tx_ValidFrame=0, Tx_RdBuff=0, Tx_AbortedTrans=0 immediately; after release, IDLE with Tx=1.
- One byte 0x55, Tx_Enable at cycle 0:
  - Tx_ValidFrame=1 at 1; Tx 2..9 = 01111110; Tx_RdBuff at 8.
  - Tx 10..17 = 1,0,1,0,1,0,1,0; Tx_ValidFrame=0 at 17.
  - Tx 18..25 = 01111110; Tx_Done=1 at 26.
- One byte 0xFF -> payload on Tx = 1,1,1,1,1,0,1,1,1 (9 cycles); end flag starts one cycle later than for 0x55; no six-ones run inside the frame.
- Three bytes 0x01,0x02,0x03 -> exactly 3 Tx_RdBuff pulses (cycles 8, 16, 24); Tx payload cycles 10..33 are contiguous LSB-first bytes.
- Abort during the second byte of a 4-byte frame -> next cycle Tx_ValidFrame=0 and Tx_AbortedTrans=1; Tx = 1 then 0,1,1,1,1,1,1,1; only 2 pops total; no Tx_Done.
- Illegal requests:
  - Tx_FrameSize=0 or 127 with Tx_Enable -> no activity, Tx stays 1.
  - Tx_Enable during DATA -> ignored; the current frame completes unchanged.
